// File: rtl/regfile_pkg.sv
// Shared constants and clear-sequencer state encoding for the multiport register file.
package regfile_pkg;

   localparam int DATA_W_DEF  = 16;
   localparam int ADDR_W_DEF  = 3;
   localparam int R0_ZERO_DEF = 0;
   localparam int BYPASS_DEF  = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } clr_state_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every register address once, writing zero, then pulses done for one cycle.
// Outputs are registered; clr_req is not acknowledged outside IDLE and is simply ignored there.
module regfile_clr_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              busy,
   output logic              done,
   output logic              sweep_we,
   output logic [ADDR_W-1:0] sweep_addr
);

   localparam logic [ADDR_W-1:0] LAST = '1;

   clr_state_t        state;
   logic [ADDR_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (clr_req) begin
                  state <= SWEEP;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            SWEEP: begin
               // Hold the counter on the last address so it never wraps mid-sweep.
               if (cnt == LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign sweep_we   = busy;
   assign sweep_addr = cnt;

endmodule

// File: rtl/multiport_regfile.sv
// One-write, two-read register file with registered reads (1 cycle), optional forwarding and bulk clear.
// No backpressure: external writes during a clear sweep are dropped, reads continue every cycle.
module multiport_regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int R0_ZERO = R0_ZERO_DEF,
   parameter int BYPASS  = BYPASS_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          we,
   input  logic [ADDR_W-1:0]             waddr,
   input  logic [DATA_W-1:0]             wdata,
   input  logic [ADDR_W-1:0]             ra_addr,
   input  logic [ADDR_W-1:0]             rb_addr,
   output logic [DATA_W-1:0]             ra_data,
   output logic [DATA_W-1:0]             rb_data,
   input  logic                          clr_req,
   output logic                          clr_busy,
   output logic                          clr_done,
   output logic [(2**ADDR_W)*DATA_W-1:0] regs_flat
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];

   logic              sweep_we;
   logic [ADDR_W-1:0] sweep_addr;

   logic              eff_we;
   logic [ADDR_W-1:0] eff_addr;
   logic [DATA_W-1:0] eff_data;
   logic              wr_ok;
   logic [DATA_W-1:0] ra_nxt;
   logic [DATA_W-1:0] rb_nxt;

   regfile_clr_seq #(
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_req    (clr_req),
      .busy       (clr_busy),
      .done       (clr_done),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr)
   );

   // The sweep owns the write port while busy; external writes are lost, not queued.
   always_comb begin
      eff_we   = we;
      eff_addr = waddr;
      eff_data = wdata;
      if (sweep_we) begin
         eff_we   = 1'b1;
         eff_addr = sweep_addr;
         eff_data = '0;
      end
      wr_ok = eff_we && !((R0_ZERO != 0) && (eff_addr == '0));
   end

   always_comb begin
      ra_nxt = regs[ra_addr];
      if ((R0_ZERO != 0) && (ra_addr == '0))
         ra_nxt = '0;
      else if ((BYPASS != 0) && wr_ok && (eff_addr == ra_addr))
         ra_nxt = eff_data;
   end

   always_comb begin
      rb_nxt = regs[rb_addr];
      if ((R0_ZERO != 0) && (rb_addr == '0))
         rb_nxt = '0;
      else if ((BYPASS != 0) && wr_ok && (eff_addr == rb_addr))
         rb_nxt = eff_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
      end else if (wr_ok) begin
         regs[eff_addr] <= eff_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra_data <= '0;
         rb_data <= '0;
      end else begin
         ra_data <= ra_nxt;
         rb_data <= rb_nxt;
      end
   end

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_flat
         if ((g == 0) && (R0_ZERO != 0)) begin : g_zero
            assign regs_flat[g*DATA_W +: DATA_W] = '0;
         end else begin : g_reg
            assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
         end
      end
   endgenerate

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench: two instances share stimulus, A = (BYPASS=1, R0_ZERO=0), B = (BYPASS=0, R0_ZERO=1).
module tb_multiport_regfile;

   logic         clk;
   logic         rst_n;
   logic         we;
   logic         clr_req;
   logic [2:0]   waddr;
   logic [2:0]   ra_addr;
   logic [2:0]   rb_addr;
   logic [15:0]  wdata;

   logic [15:0]  ra_a, rb_a, ra_b, rb_b;
   logic         busy_a, done_a, busy_b, done_b;
   logic [127:0] flat_a, flat_b;

   int           checks = 0;
   int           errors = 0;
   logic [15:0]  exp_a [8];
   logic [15:0]  exp_b [8];
   logic         saw;

   multiport_regfile #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(0), .BYPASS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_a), .rb_data(rb_a),
      .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a), .regs_flat(flat_a)
   );

   multiport_regfile #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(1), .BYPASS(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_b), .rb_data(rb_b),
      .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b), .regs_flat(flat_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_flat(input string tag);
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_flat_a"}, flat_a[i*16 +: 16], exp_a[i]);
         chk({tag, "_flat_b"}, flat_b[i*16 +: 16], exp_b[i]);
      end
   endtask

   task automatic write_both(input logic [2:0] a, input logic [15:0] d);
      we    = 1'b1;
      waddr = a;
      wdata = d;
      tick();
      we = 1'b0;
      exp_a[a] = d;
      if (a != 3'd0) exp_b[a] = d;
   endtask

   task automatic load_all();
      for (int i = 0; i < 8; i++)
         write_both(3'(i), 16'(16'h1111 * (i + 1)));
   endtask

   initial begin
      rst_n   = 1'b1;
      we      = 1'b0;
      clr_req = 1'b0;
      waddr   = '0;
      wdata   = '0;
      ra_addr = '0;
      rb_addr = '0;
      for (int i = 0; i < 8; i++) begin
         exp_a[i] = '0;
         exp_b[i] = '0;
      end

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_ra_a", ra_a, 16'h0);
      chk("rst_rb_a", rb_a, 16'h0);
      chk("rst_ra_b", ra_b, 16'h0);
      chk("rst_busy_a", busy_a, 1'b0);
      chk("rst_done_a", done_a, 1'b0);
      chk("rst_busy_b", busy_b, 1'b0);
      chk_flat("rst");
      #2 rst_n = 1'b1;

      for (int a = 0; a < 8; a++) begin
         ra_addr = 3'(a);
         rb_addr = 3'(7 - a);
         tick();
         chk("rd0_ra_a", ra_a, 16'h0);
         chk("rd0_rb_b", rb_b, 16'h0);
      end

      // Write r5, read both ports one cycle later
      ra_addr = 3'd0;
      rb_addr = 3'd0;
      write_both(3'd5, 16'hBEEF);
      ra_addr = 3'd5;
      rb_addr = 3'd5;
      tick();
      chk("beef_ra_a", ra_a, 16'hBEEF);
      chk("beef_rb_a", rb_a, 16'hBEEF);
      chk("beef_ra_b", ra_b, 16'hBEEF);
      chk("beef_rb_b", rb_b, 16'hBEEF);

      // Same-edge write/read of r3
      ra_addr = 3'd3;
      write_both(3'd3, 16'h1234);
      chk("byp_ra_a", ra_a, 16'h1234);
      chk("byp_ra_b", ra_b, 16'h0000);
      chk("byp_rb_a", rb_a, 16'hBEEF);
      tick();
      chk("nobyp_next_ra_b", ra_b, 16'h1234);

      // Register 0 handling
      ra_addr = 3'd0;
      rb_addr = 3'd0;
      write_both(3'd0, 16'hFFFF);
      chk("r0_byp_ra_a", ra_a, 16'hFFFF);
      chk("r0_ra_b", ra_b, 16'h0000);
      tick();
      chk("r0_ra_a", ra_a, 16'hFFFF);
      chk("r0_ra_b2", ra_b, 16'h0000);
      chk("r0_rb_b", rb_b, 16'h0000);
      chk("r0_flat_a", flat_a[15:0], 16'hFFFF);
      chk("r0_flat_b", flat_b[15:0], 16'h0000);

      // Fill all registers and read back on independent ports
      load_all();
      chk_flat("load");
      for (int i = 0; i < 8; i++) begin
         ra_addr = 3'(i);
         rb_addr = 3'(7 - i);
         tick();
         chk("load_ra_a", ra_a, exp_a[i]);
         chk("load_rb_b", rb_b, exp_b[7 - i]);
      end

      // Clear sweep with a dropped external write and an ignored clr_req
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("swp_busy_a", busy_a, 1'b1);
         chk("swp_done_a", done_a, 1'b0);
         chk("swp_busy_b", busy_b, 1'b1);
         if (i == 4) begin
            we      = 1'b1;
            waddr   = 3'd2;
            wdata   = 16'hAAAA;
            clr_req = 1'b1;
         end else begin
            we      = 1'b0;
            clr_req = 1'b0;
         end
         tick();
      end
      we      = 1'b0;
      clr_req = 1'b1;
      chk("done_busy_a", busy_a, 1'b0);
      chk("done_pulse_a", done_a, 1'b1);
      chk("done_pulse_b", done_b, 1'b1);
      tick();
      clr_req = 1'b0;
      chk("post_done_a", done_a, 1'b0);
      chk("post_busy_a", busy_a, 1'b0);
      tick();
      chk("idle_busy_a", busy_a, 1'b0);
      chk("idle_done_a", done_a, 1'b0);
      for (int i = 0; i < 8; i++) begin
         exp_a[i] = '0;
         exp_b[i] = '0;
      end
      chk_flat("clr");

      // Reset during sweep cycle 3
      load_all();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick();
      tick();
      tick();
      chk("mid_busy_a", busy_a, 1'b1);
      chk("mid_r7_a", flat_a[127:112], 16'h8888);
      rst_n = 1'b0;
      #1;
      chk("arst_busy_a", busy_a, 1'b0);
      chk("arst_busy_b", busy_b, 1'b0);
      chk("arst_done_a", done_a, 1'b0);
      chk("arst_ra_a", ra_a, 16'h0);
      for (int i = 0; i < 8; i++) begin
         exp_a[i] = '0;
         exp_b[i] = '0;
      end
      chk_flat("arst");
      @(posedge clk);
      #2 rst_n = 1'b1;

      // First edge after reset release behaves as IDLE
      we      = 1'b1;
      waddr   = 3'd6;
      wdata   = 16'h5A5A;
      ra_addr = 3'd6;
      tick();
      we = 1'b0;
      chk("rel_ra_a", ra_a, 16'h5A5A);
      chk("rel_ra_b", ra_b, 16'h0000);
      saw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         saw = saw | done_a | done_b | busy_a | busy_b;
      end
      chk("no_done_after_abort", saw, 1'b0);
      chk("rel_next_ra_b", ra_b, 16'h5A5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the register data width in bits.
REQ-002 Parameter ADDR_W, default 3, SHALL set the address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter R0_ZERO, default 0, SHALL make register 0 read-only zero when 1.
REQ-004 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when 1.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 we  in  1  write enable.
REQ-008 waddr  in  ADDR_W  write address.
REQ-009 wdata  in  DATA_W  write data.
REQ-010 ra_addr, rb_addr  in  ADDR_W  read port A and B addresses.
REQ-011 ra_data, rb_data  out  DATA_W  registered read data, ports A and B.
REQ-012 clr_req  in  1  request to zero all registers.
REQ-013 clr_busy  out  1  high while a clear sweep is in progress.
REQ-014 clr_done  out  1  one-cycle pulse when a sweep completes.
REQ-015 regs_flat  out  DEPTH*DATA_W  debug view of all registers; register i at bits [i*DATA_W +: DATA_W].

Function
REQ-016 Reads SHALL have 1-cycle latency: after edge k, ra_data/rb_data hold the register addressed at edge k.
REQ-017 With BYPASS=1, if an effective write (REQ-021) targets the read address at the same edge, read data SHALL be the written value; with BYPASS=0, it SHALL be the pre-write value.
REQ-018 With R0_ZERO=1, writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, and bypass SHALL never forward to address 0.
REQ-019 Both read ports SHALL operate independently, including both addressing the same register.
REQ-020 The clear FSM SHALL have states IDLE, SWEEP and DONE.
REQ-021 The effective write SHALL be the external write (we, waddr, wdata) in IDLE and DONE, and the sweep write (counter, 0) in SWEEP.
REQ-022 IDLE->SWEEP SHALL occur on an edge with clr_req=1; the counter SHALL be loaded with 0, and an external write at that same edge SHALL still commit.
REQ-023 SWEEP SHALL zero register[counter] at each edge and increment the counter; at counter = DEPTH-1 the FSM SHALL go to DONE (DEPTH sweep cycles in total).
REQ-024 DONE SHALL last one cycle with clr_done=1 and then return to IDLE; clr_req in DONE SHALL be ignored.
REQ-025 In SWEEP, external writes SHALL be dropped silently, clr_req SHALL be ignored, and reads SHALL continue per REQ-016/017.
REQ-026 clr_busy SHALL be 1 exactly while in SWEEP.
REQ-027 The counter SHALL be ADDR_W bits wide and SHALL not wrap beyond DEPTH-1 within a sweep.
REQ-028 regs_flat SHALL reflect register contents combinationally from state; with R0_ZERO=1, slot 0 SHALL read 0.

Reset
REQ-029 rst_n low SHALL immediately zero all registers, ra_data, rb_data and the counter, force the FSM to IDLE, and force clr_busy=0 and clr_done=0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep; no clr_done pulse SHALL follow.
REQ-031 After rst_n deassertion, the first edge SHALL behave as IDLE.

Structure
REQ-032 Package regfile_pkg SHALL hold the FSM state typedef (IDLE/SWEEP/DONE) and the default constants for DATA_W, ADDR_W, R0_ZERO and BYPASS.
REQ-033 The clear FSM and counter SHALL be the sub-module regfile_clr_seq, with outputs busy, done, sweep_we and sweep_addr.
REQ-034 The storage array, write mux, bypass and read registers SHALL reside in multiport_regfile.

Verification
REQ-035 Reset then read all addresses -> ra_data=rb_data=0; regs_flat all zero.
REQ-036 Write 0xBEEF to r5, and one cycle later read A=5, B=5 -> both 0xBEEF one edge after the address is applied.
REQ-037 Same-edge write 0x1234 to r3 with ra_addr=3 -> BYPASS=1: ra_data=0x1234; BYPASS=0: old value, then 0x1234 on the next read.
REQ-038 R0_ZERO=1, write 0xFFFF to r0 -> ra_data(0)=0 and regs_flat slot 0 = 0.
REQ-039 Load all 8 registers with nonzero values, pulse clr_req, issue we to r2 during SWEEP -> clr_busy high for 8 cycles, clr_done pulses once, all registers 0, and r2 write dropped.
REQ-040 Assert rst_n low at sweep cycle 3 -> all registers 0, clr_busy=0 immediately, and no clr_done pulse afterwards.
